// File: rtl/delay_pkg.sv
// Shared constants and sizing helper for the delay_pipe block.
package delay_pkg;

  localparam int DELAY_CYCLES_DEF = 4;
  localparam int DELAY_WIDTH_DEF  = 8;

  // Occupancy counter width; at least one bit even for the pass-through build.
  function automatic int occ_width(int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One register stage of delay_pipe: a valid bit plus a data word that only
// updates when the incoming beat is valid.
module delay_pipe_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DELAY_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/delay_pipe.sv
// Elastic valid/ready delay line of CYCLES stages with bubble squeezing and flush.
// Define DELAY_PIPE_OCC_EN to add the registered occupancy_o count.
module delay_pipe
  import delay_pkg::*;
#(
  parameter int CYCLES = DELAY_CYCLES_DEF,
  parameter int WIDTH  = DELAY_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [WIDTH-1:0]              in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [WIDTH-1:0]              out_data_o
`ifdef DELAY_PIPE_OCC_EN
  ,
  output logic [occ_width(CYCLES)-1:0]  occupancy_o
`endif
);

  if (CYCLES < 0 || WIDTH < 1) begin : g_param_check
    $error("delay_pipe: CYCLES must be >= 0 and WIDTH must be >= 1");
  end

  if (CYCLES == 0) begin : g_bypass
    assign out_valid_o = in_valid_i;
    assign out_data_o  = in_data_i;
    assign in_ready_o  = out_ready_i;
`ifdef DELAY_PIPE_OCC_EN
    assign occupancy_o = '0;
`endif
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_i, flush_i};
  end else begin : g_pipe
    logic [CYCLES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [CYCLES];
    logic [CYCLES:0]   rdy;

    // A stage may load if it is empty or everything downstream of it can move.
    always_comb begin
      rdy         = '0;
      rdy[CYCLES] = out_ready_i;
      for (int i = CYCLES - 1; i >= 0; i--) begin
        rdy[i] = !valid_q[i] | rdy[i+1];
      end
    end

    for (genvar i = 0; i < CYCLES; i++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_head
        assign up_valid = in_valid_i;
        assign up_data  = in_data_i;
      end else begin : g_body
        assign up_valid = valid_q[i-1];
        assign up_data  = data_q[i-1];
      end

      delay_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .load_i  (rdy[i]),
        .valid_i (up_valid),
        .data_i  (up_data),
        .valid_o (valid_q[i]),
        .data_o  (data_q[i])
      );
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = valid_q[CYCLES-1];
    assign out_data_o  = data_q[CYCLES-1];

`ifdef DELAY_PIPE_OCC_EN
    localparam int CW = occ_width(CYCLES);
    logic [CW-1:0] occ_q, occ_d;
    logic          in_xfer, out_xfer;

    assign in_xfer  = in_valid_i & rdy[0];
    assign out_xfer = valid_q[CYCLES-1] & out_ready_i;

    always_comb begin
      occ_d = occ_q;
      if (flush_i) begin
        occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
        occ_d = occ_q + CW'(1);
      end else if (!in_xfer && out_xfer) begin
        occ_d = occ_q - CW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end

    assign occupancy_o = occ_q;
`endif
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Self-checking bench for delay_pipe (CYCLES=4 instance plus a CYCLES=0 pass-through).
// Occupancy is checked when DELAY_PIPE_OCC_EN is defined.
module tb_delay_pipe;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0] p_in_data, p_out_data;
`ifdef DELAY_PIPE_OCC_EN
  logic [2:0] occupancy;
  logic [0:0] p_occupancy;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  delay_pipe #(.CYCLES(C), .WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef DELAY_PIPE_OCC_EN
    ,
    .occupancy_o (occupancy)
`endif
  );

  delay_pipe #(.CYCLES(0), .WIDTH(8)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (p_in_valid),
    .in_ready_o  (p_in_ready),
    .in_data_i   (p_in_data),
    .out_valid_o (p_out_valid),
    .out_ready_i (p_out_ready),
    .out_data_o  (p_out_data)
`ifdef DELAY_PIPE_OCC_EN
    ,
    .occupancy_o (p_occupancy)
`endif
  );

  // Reference model: beats in flight, oldest first, each with its stage position.
  // A beat moves forward unless it and every beat ahead of it is packed against a
  // stalled output.
  logic [7:0] m_data[$];
  int         m_pos[$];

  function automatic bit exp_ov();
    return (m_pos.size() > 0) && (m_pos[0] == C - 1);
  endfunction

  function automatic bit exp_ir();
    return (m_data.size() < C) || (out_ready == 1'b1);
  endfunction

  task automatic model_step();
    bit         in_x, out_x;
    logic [7:0] nd[$];
    int         np[$];
    in_x  = (in_valid == 1'b1) && exp_ir();
    out_x = exp_ov() && (out_ready == 1'b1);
    cyc++;
    if (rst) begin
      m_data.delete();
      m_pos.delete();
      return;
    end
    for (int k = 0; k < m_pos.size(); k++) begin
      if (k == 0 && out_x) continue;
      nd.push_back(m_data[k]);
      np.push_back((out_ready || m_pos[k] < C - 1 - k) ? m_pos[k] + 1 : m_pos[k]);
    end
    if (flush) begin
      nd.delete();
      np.delete();
    end else if (in_x) begin
      nd.push_back(in_data);
      np.push_back(0);
    end
    m_data = nd;
    m_pos  = np;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  // Output monitor: records completed output beats and checks stall stability.
  logic [7:0] rx[$];
  bit         stall_prev = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    #2;
    if (stall_prev) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_data) begin
        errors++;
        $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, hold_data);
      end
    end
    stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && !flush && !rst;
    hold_data  = out_data;
    if (out_valid === 1'b1 && out_ready === 1'b1 && !rst) rx.push_back(out_data);
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
`ifdef DELAY_PIPE_OCC_EN
    checks++;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
`endif
    tick();
  endtask

  task automatic test_stream();
    int first_acc = -1;
    int first_out = -1;
    rx.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i + 1);
      #1;
      if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
      if (out_valid && first_out < 0) first_out = cyc;
      checks++;
      if (out_valid !== exp_ov()) begin
        errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, out_valid, exp_ov());
      end
      checks++;
      if (in_ready !== exp_ir()) begin
        errors++; $display("FAIL stream_ready cyc %0d got %b exp %b", i, in_ready, exp_ir());
      end
      if (exp_ov()) begin
        checks++;
        if (out_data !== m_data[0]) begin
          errors++; $display("FAIL stream_data cyc %0d got %h exp %h", i, out_data, m_data[0]);
        end
      end
      tick();
    end
    checks++;
    if (first_out - first_acc != C) begin
      errors++; $display("FAIL stream_latency got %0d exp %0d", first_out - first_acc, C);
    end
    checks++;
    if (rx.size() != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", rx.size()); end
    for (int i = 0; i < 16 && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL stream_order idx %0d got %h exp %h", i, rx[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    int acc = 0;
    rx.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (nxt <= 6);
      in_data  = 8'(nxt);
      #1;
      checks++;
      if (in_ready !== exp_ir()) begin
        errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", i, in_ready, exp_ir());
      end
      if (in_valid && in_ready) acc++;
      if (in_valid && exp_ir()) nxt++;
      tick();
    end
    in_valid = 1'b1;
    in_data  = 8'(nxt);
    #1;
    checks++;
    if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", acc); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=01", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = (nxt <= 6);
      in_data  = 8'(nxt);
      #1;
      checks++;
      if (out_valid !== exp_ov()) begin
        errors++; $display("FAIL bp_valid cyc %0d got %b exp %b", i, out_valid, exp_ov());
      end
      if (in_valid && exp_ir()) nxt++;
      tick();
    end
    checks++;
    if (rx.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", rx.size()); end
    for (int i = 0; i < 6 && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL bp_order idx %0d got %h exp %h", i, rx[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_sparse_full();
    logic [7:0] sent[$];
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0) && (i < 10);
      in_data  = 8'($urandom);
      if (in_valid) sent.push_back(in_data);
      #1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== sent[0]) begin
      errors++; $display("FAIL sparse_head got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sent[0]);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL sparse_ready got %b exp 0", in_ready); end
`ifdef DELAY_PIPE_OCC_EN
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL sparse_occ got %0d exp 4", occupancy); end
`endif
    // Full pipe with both sides active: accept and emit in the same cycle.
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_ready got %b exp 1", in_ready); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== sent[1]) begin
      errors++; $display("FAIL full_pass_next got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sent[1]);
    end
`ifdef DELAY_PIPE_OCC_EN
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL full_pass_occ got %0d exp 4", occupancy); end
`endif
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rx.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      tick();
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
`ifdef DELAY_PIPE_OCC_EN
    checks++;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
`endif
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (rx.size() != 0) begin errors++; $display("FAIL flush_leak got %0d beats exp 0", rx.size()); end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      tick();
    end
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
`ifdef DELAY_PIPE_OCC_EN
    checks++;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL rstmid_occ got %0d exp 0", occupancy); end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = 8'($urandom);
      #1;
      checks++;
      if (out_valid !== exp_ov()) begin
        errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, out_valid, exp_ov());
      end
      checks++;
      if (in_ready !== exp_ir()) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", i, in_ready, exp_ir());
      end
      if (exp_ov()) begin
        checks++;
        if (out_data !== m_data[0]) begin
          errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, out_data, m_data[0]);
        end
      end
`ifdef DELAY_PIPE_OCC_EN
      checks++;
      if (occupancy !== 3'(m_data.size())) begin
        errors++; $display("FAIL rand_occ cyc %0d got %0d exp %0d", i, occupancy, m_data.size());
      end
`endif
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_passthru();
    for (int i = 0; i < 24; i++) begin
      p_in_valid  = 1'($urandom);
      p_out_ready = 1'($urandom);
      p_in_data   = 8'($urandom);
      #1;
      checks++;
      if (p_out_valid !== p_in_valid || p_out_data !== p_in_data || p_in_ready !== p_out_ready) begin
        errors++;
        $display("FAIL passthru cyc %0d got v=%b d=%h r=%b exp v=%b d=%h r=%b", i, p_out_valid,
                 p_out_data, p_in_ready, p_in_valid, p_in_data, p_out_ready);
      end
`ifdef DELAY_PIPE_OCC_EN
      checks++;
      if (p_occupancy !== 1'b0) begin errors++; $display("FAIL passthru_occ got %0d exp 0", p_occupancy); end
`endif
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = 8'h00; p_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_sparse_full();
    test_flush();
    test_rst_mid();
    test_random();
    test_passthru();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
